npu_sched: RTL and testbench

Sequencer that sits between the decode stage and the NPU. Accepts decoded matrix-multiply and convolution instructions with their operand values, buffers them in a small in-order command queue, and issues them one at a time to the NPU over a valid/ready handshake. It waits for completion with a timeout, then returns the scalar result to the register file through a handshaked write-back port. The core pipeline stalls only when the queue is full.

---
 rtl/osyrys64_pkg.sv | 28 ++
 rtl/npu_cmd_fifo.sv | 57 +++++
 rtl/npu_sched.sv | 165 ++++++++++++++++
 tb/tb_npu_sched.sv | 504 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osyrys64_pkg.sv
// osyrys64 shared types for the NPU sequencer.
// Holds the opcode enum, the queued command bundle, the FSM states and the default timeout.
package osyrys64_pkg;

   localparam int NPU_XLEN            = 64;
   localparam int NPU_TIMEOUT_DEFAULT = 1024;

   typedef enum logic [1:0] {
      NPU_NONE   = 2'd0,
      NPU_MATMUL = 2'd1,
      NPU_CONV   = 2'd2
   } npu_op_t;

   typedef struct packed {
      npu_op_t               op;
      logic [NPU_XLEN-1:0]   a;
      logic [NPU_XLEN-1:0]   b;
      logic [4:0]            rd;
   } npu_cmd_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_WB    = 2'd3
   } npu_sched_state_t;

endpackage

// File: rtl/npu_cmd_fifo.sv
// In-order command queue for the NPU sequencer.
// Ports: push_i/wdata_i write tail, pop_i advances head (rdata_o), flush_i empties, full_o/empty_o/count_o status.
module npu_cmd_fifo
   import osyrys64_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push_i,
   input  npu_cmd_t    wdata_i,
   input  logic        pop_i,
   input  logic        flush_i,
   output npu_cmd_t    rdata_o,
   output logic        full_o,
   output logic        empty_o,
   output logic [AW:0] count_o
);

   npu_cmd_t      mem_q [DEPTH];
   logic [AW-1:0] wptr_q;
   logic [AW-1:0] rptr_q;
   logic [AW:0]   cnt_q;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rptr_q];

   // flush dominates both push and pop
   assign do_push = push_i & ~full_o & ~flush_i;
   assign do_pop  = pop_i & ~empty_o & ~flush_i;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else if (flush_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/npu_sched.sv
// NPU sequencer: queues decoded NPU ops, issues them one at a time, waits with timeout, writes back.
// Ports: issue_* from decode, npu_cmd_*/npu_done/npu_result to NPU, wb_* to regfile, busy/err status.
module npu_sched
   import osyrys64_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int QDEPTH  = 2,
   parameter int TIMEOUT = NPU_TIMEOUT_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            issue_valid,
   input  npu_op_t         issue_op,
   input  logic [XLEN-1:0] issue_a,
   input  logic [XLEN-1:0] issue_b,
   input  logic [4:0]      issue_rd,
   output logic            issue_ready,
   output logic            stall,
   input  logic            flush,
   output logic            npu_cmd_valid,
   output npu_op_t         npu_cmd_op,
   output logic [XLEN-1:0] npu_cmd_a,
   output logic [XLEN-1:0] npu_cmd_b,
   input  logic            npu_cmd_ready,
   input  logic            npu_done,
   input  logic [XLEN-1:0] npu_result,
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   input  logic            wb_ready,
   output logic            busy,
   output logic            err,
   input  logic            err_clr
);

   localparam int TW = $clog2(TIMEOUT);
   localparam int CW = $clog2(QDEPTH) + 1;

   npu_sched_state_t state_q, state_d;
   npu_cmd_t         cmd_q, cmd_d;
   npu_cmd_t         in_cmd, head;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic             err_q, err_d;
   logic [4:0]       wb_rd_q, wb_rd_d;
   logic [XLEN-1:0]  wb_data_q, wb_data_d;
   logic [XLEN-1:0]  res;
   logic [CW-1:0]    count;
   logic             full, empty;
   logic             push_ok, fifo_push, fifo_pop;
   logic             bypass, load_next, tmo_last;

   always_comb begin
      in_cmd             = '0;
      in_cmd.op          = issue_op;
      in_cmd.a[XLEN-1:0] = issue_a;
      in_cmd.b[XLEN-1:0] = issue_b;
      in_cmd.rd          = issue_rd;
   end

   assign push_ok   = issue_valid & ~full & ~flush;
   assign fifo_push = push_ok & ~bypass;

   // abort on the cycle the counter would step to TIMEOUT-1,
   // so write-back lands TIMEOUT cycles after the command handshake
   assign tmo_last = (tmo_q == TW'(TIMEOUT - 2));

   npu_cmd_fifo #(.DEPTH(QDEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .wdata_i (in_cmd),
      .pop_i   (fifo_pop),
      .flush_i (flush),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      tmo_d     = tmo_q;
      err_d     = err_q & ~err_clr;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
      res       = npu_result;
      fifo_pop  = 1'b0;
      bypass    = 1'b0;
      load_next = 1'b0;

      unique case (state_q)
         S_IDLE: load_next = 1'b1;
         S_ISSUE: begin
            if (npu_cmd_ready) begin
               state_d = S_WAIT;
               tmo_d   = '0;
            end
         end
         S_WAIT: begin
            tmo_d = tmo_q + 1'b1;
            if (npu_done || tmo_last) begin
               if (!npu_done) begin
                  res   = '1;
                  err_d = 1'b1;
               end
               if (cmd_q.rd == 5'd0) begin
                  load_next = 1'b1;
               end else begin
                  state_d   = S_WB;
                  wb_rd_d   = cmd_q.rd;
                  wb_data_d = res;
               end
            end
         end
         S_WB: load_next = wb_ready;
      endcase

      // queued work first; an empty queue lets a same-cycle push
      // go straight into the command register
      if (load_next) begin
         state_d = S_IDLE;
         if (!empty && !flush) begin
            fifo_pop = 1'b1;
            cmd_d    = head;
            state_d  = S_ISSUE;
         end else if (push_ok) begin
            bypass  = 1'b1;
            cmd_d   = in_cmd;
            state_d = S_ISSUE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cmd_q     <= '0;
         tmo_q     <= '0;
         err_q     <= 1'b0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         tmo_q     <= tmo_d;
         err_q     <= err_d;
         wb_rd_q   <= wb_rd_d;
         wb_data_q <= wb_data_d;
      end
   end

   assign issue_ready   = ~full;
   assign stall         = issue_valid & full;
   assign npu_cmd_valid = (state_q == S_ISSUE);
   assign npu_cmd_op    = cmd_q.op;
   assign npu_cmd_a     = cmd_q.a[XLEN-1:0];
   assign npu_cmd_b     = cmd_q.b[XLEN-1:0];
   assign wb_valid      = (state_q == S_WB);
   assign wb_rd         = wb_rd_q;
   assign wb_data       = wb_data_q;
   assign busy          = (state_q != S_IDLE) | (count != '0);
   assign err           = err_q;

endmodule

// File: tb/tb_npu_sched.sv
// Bench for npu_sched: directed scenarios plus randomized traffic
// against a queue-based model of issue order and write-back.
module tb_npu_sched;
   import osyrys64_pkg::*;

   localparam int XLEN   = 64;
   localparam int QDEPTH = 2;
   localparam int TMO    = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            issue_valid;
   npu_op_t         issue_op;
   logic [XLEN-1:0] issue_a, issue_b;
   logic [4:0]      issue_rd;
   logic            issue_ready, stall, flush;
   logic            npu_cmd_valid;
   npu_op_t         npu_cmd_op;
   logic [XLEN-1:0] npu_cmd_a, npu_cmd_b;
   logic            npu_cmd_ready, npu_done;
   logic [XLEN-1:0] npu_result;
   logic            wb_valid;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            wb_ready, busy, err, err_clr;

   npu_sched #(.XLEN(XLEN), .QDEPTH(QDEPTH), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_op(issue_op),
      .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd),
      .issue_ready(issue_ready), .stall(stall), .flush(flush),
      .npu_cmd_valid(npu_cmd_valid), .npu_cmd_op(npu_cmd_op),
      .npu_cmd_a(npu_cmd_a), .npu_cmd_b(npu_cmd_b),
      .npu_cmd_ready(npu_cmd_ready), .npu_done(npu_done),
      .npu_result(npu_result),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_ready(wb_ready), .busy(busy), .err(err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;

   typedef struct {
      npu_op_t     op;
      logic [63:0] a;
      logic [63:0] b;
      logic [4:0]  rd;
   } mcmd_t;

   mcmd_t       exp_cmd[$];
   logic [4:0]  exp_rd[$];
   logic [63:0] exp_dat[$];
   bit          rnd;
   int          npu_lat;
   logic [4:0]  npu_rd;
   logic [63:0] npu_res;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      issue_valid   = 1'b0;
      issue_op      = NPU_NONE;
      issue_a       = '0;
      issue_b       = '0;
      issue_rd      = '0;
      flush         = 1'b0;
      npu_cmd_ready = 1'b0;
      npu_done      = 1'b0;
      npu_result    = '0;
      wb_ready      = 1'b0;
      err_clr       = 1'b0;
   endtask

   task automatic model_clear();
      exp_cmd.delete();
      exp_rd.delete();
      exp_dat.delete();
      npu_lat = 0;
   endtask

   function automatic mcmd_t rand_cmd(input bit allow_rd0);
      mcmd_t c;
      c.op = ($urandom_range(0, 1) == 0) ? NPU_MATMUL : NPU_CONV;
      c.a  = {$urandom, $urandom};
      c.b  = {$urandom, $urandom};
      if (allow_rd0 && $urandom_range(0, 3) == 0) c.rd = 5'd0;
      else c.rd = 5'($urandom_range(1, 31));
      return c;
   endfunction

   task automatic drive_issue(input mcmd_t c);
      issue_valid = 1'b1;
      issue_op    = c.op;
      issue_a     = c.a;
      issue_b     = c.b;
      issue_rd    = c.rd;
   endtask

   // One cycle of NPU + register-file behaviour, checked against the model queues
   task automatic agent_step();
      mcmd_t m;
      npu_done = 1'b0;
      if (npu_lat > 0) begin
         npu_lat--;
         if (npu_lat == 0) begin
            npu_done   = 1'b1;
            npu_result = npu_res;
            if (npu_rd != 5'd0) begin
               exp_rd.push_back(npu_rd);
               exp_dat.push_back(npu_res);
            end
         end
      end
      npu_cmd_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (npu_cmd_valid && npu_cmd_ready) begin
         vecs++;
         if (exp_cmd.size() == 0) begin
            errs++;
            $display("FAIL issue: unexpected command op=%0d a=%h", npu_cmd_op, npu_cmd_a);
         end else begin
            m = exp_cmd.pop_front();
            if (npu_cmd_op !== m.op || npu_cmd_a !== m.a || npu_cmd_b !== m.b) begin
               errs++;
               $display("FAIL issue: got op=%0d a=%h b=%h exp op=%0d a=%h b=%h",
                        npu_cmd_op, npu_cmd_a, npu_cmd_b, m.op, m.a, m.b);
            end
            npu_lat = rnd ? $urandom_range(1, 6) : 3;
            npu_rd  = m.rd;
            npu_res = {$urandom, $urandom};
         end
      end
      wb_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (wb_valid && wb_ready) begin
         vecs++;
         if (exp_rd.size() == 0) begin
            errs++;
            $display("FAIL wb: unexpected write-back rd=%0d data=%h", wb_rd, wb_data);
         end else begin
            logic [4:0]  r;
            logic [63:0] d;
            r = exp_rd.pop_front();
            d = exp_dat.pop_front();
            if (wb_rd !== r || wb_data !== d) begin
               errs++;
               $display("FAIL wb: got rd=%0d data=%h exp rd=%0d data=%h", wb_rd, wb_data, r, d);
            end
         end
      end
   endtask

   task automatic drain(input int budget);
      bit done_ok = 1'b0;
      for (int n = 0; n < budget; n++) begin
         if (!busy && exp_cmd.size() == 0 && exp_rd.size() == 0 && npu_lat == 0) begin
            done_ok = 1'b1;
            break;
         end
         agent_step();
         tick();
      end
      vecs++;
      if (!done_ok) begin
         errs++;
         $display("FAIL drain: not idle after %0d cycles, busy=%b cmds=%0d wbs=%0d",
                  budget, busy, exp_cmd.size(), exp_rd.size());
      end
      idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      vecs++; if (issue_ready !== 1'b1) begin errs++; $display("FAIL reset issue_ready got %b exp 1", issue_ready); end
      vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL reset stall got %b exp 0", stall); end
      vecs++; if (npu_cmd_valid !== 1'b0) begin errs++; $display("FAIL reset cmd_valid got %b exp 0", npu_cmd_valid); end
      vecs++; if (npu_cmd_op !== NPU_NONE) begin errs++; $display("FAIL reset cmd_op got %0d exp 0", npu_cmd_op); end
      vecs++; if (npu_cmd_a !== '0 || npu_cmd_b !== '0) begin errs++; $display("FAIL reset cmd_ab got %h %h exp 0", npu_cmd_a, npu_cmd_b); end
      vecs++; if (wb_valid !== 1'b0) begin errs++; $display("FAIL reset wb_valid got %b exp 0", wb_valid); end
      vecs++; if (wb_rd !== '0 || wb_data !== '0) begin errs++; $display("FAIL reset wb_rd/data got %0d %h exp 0", wb_rd, wb_data); end
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset busy got %b exp 0", busy); end
      vecs++; if (err !== 1'b0) begin errs++; $display("FAIL reset err got %b exp 0", err); end
      rst = 1'b0;
      model_clear();
      tick();
   endtask

   task automatic test_single();
      bit early = 1'b0;
      issue_valid   = 1'b1;
      issue_op      = NPU_MATMUL;
      issue_a       = 64'h1000;
      issue_b       = 64'h2000;
      issue_rd      = 5'd5;
      npu_cmd_ready = 1'b1;
      wb_ready      = 1'b1;
      #1;
      vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL single stall got %b exp 0", stall); end
      tick();
      issue_valid = 1'b0;
      vecs++;
      if (npu_cmd_valid !== 1'b1 || npu_cmd_op !== NPU_MATMUL ||
          npu_cmd_a !== 64'h1000 || npu_cmd_b !== 64'h2000) begin
         errs++;
         $display("FAIL single cmd got v=%b op=%0d a=%h b=%h exp 1 1 1000 2000",
                  npu_cmd_valid, npu_cmd_op, npu_cmd_a, npu_cmd_b);
      end
      tick();
      vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL single busy_wait got %b exp 1", busy); end
      repeat (9) begin
         if (wb_valid !== 1'b0 || npu_cmd_valid !== 1'b0) early = 1'b1;
         tick();
      end
      vecs++; if (early) begin errs++; $display("FAIL single quiet_wait got activity exp none"); end
      npu_done   = 1'b1;
      npu_result = 64'hDEAD;
      tick();
      npu_done   = 1'b0;
      npu_result = {$urandom, $urandom};
      vecs++;
      if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 64'hDEAD) begin
         errs++;
         $display("FAIL single wb got v=%b rd=%0d data=%h exp 1 5 dead", wb_valid, wb_rd, wb_data);
      end
      tick();
      vecs++;
      if (wb_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
         errs++;
         $display("FAIL single end got wb_valid=%b busy=%b err=%b exp 0 0 0", wb_valid, busy, err);
      end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      mcmd_t c[4];
      bit    moved = 1'b0;
      bit    pushed = 1'b0;
      rnd = 1'b0;
      for (int i = 0; i < 4; i++) c[i] = rand_cmd(1'b0);
      wb_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_issue(c[i]);
         #1;
         vecs++; if (issue_ready !== 1'b1) begin errs++; $display("FAIL b2b ready%0d got 0 exp 1", i); end
         exp_cmd.push_back(c[i]);
         tick();
      end
      drive_issue(c[3]);
      #1;
      vecs++;
      if (issue_ready !== 1'b0 || stall !== 1'b1) begin
         errs++;
         $display("FAIL b2b full got ready=%b stall=%b exp 0 1", issue_ready, stall);
      end
      for (int i = 0; i < 3; i++) begin
         if (npu_cmd_valid !== 1'b1 || npu_cmd_a !== c[0].a) moved = 1'b1;
         tick();
      end
      vecs++; if (moved) begin errs++; $display("FAIL b2b hold got a=%h exp %h", npu_cmd_a, c[0].a); end
      for (int n = 0; n < 50 && !pushed; n++) begin
         bit acc;
         acc = issue_valid && issue_ready;
         if (acc) exp_cmd.push_back(c[3]);
         agent_step();
         tick();
         if (acc) begin
            issue_valid = 1'b0;
            pushed = 1'b1;
         end
      end
      vecs++; if (!pushed) begin errs++; $display("FAIL b2b push4 got stuck exp accepted"); end
      drain(200);
   endtask

   task automatic test_rd0();
      mcmd_t c0, c1;
      c0 = rand_cmd(1'b0);
      c0.op = NPU_CONV;
      c0.rd = 5'd0;
      c1 = rand_cmd(1'b0);
      c1.op = NPU_MATMUL;
      c1.rd = 5'd3;
      npu_cmd_ready = 1'b1;
      wb_ready = 1'b1;
      drive_issue(c0);
      tick();
      drive_issue(c1);
      vecs++; if (npu_cmd_op !== NPU_CONV) begin errs++; $display("FAIL rd0 op got %0d exp 2", npu_cmd_op); end
      tick();
      issue_valid = 1'b0;
      npu_cmd_ready = 1'b0;
      tick();
      npu_done = 1'b1;
      npu_result = {$urandom, $urandom};
      tick();
      npu_done = 1'b0;
      vecs++;
      if (wb_valid !== 1'b0 || npu_cmd_valid !== 1'b1 ||
          npu_cmd_op !== NPU_MATMUL || npu_cmd_a !== c1.a) begin
         errs++;
         $display("FAIL rd0 next got wb=%b v=%b op=%0d a=%h exp 0 1 1 %h",
                  wb_valid, npu_cmd_valid, npu_cmd_op, npu_cmd_a, c1.a);
      end
      exp_cmd.push_back(c1);
      drain(100);
   endtask

   task automatic test_timeout();
      mcmd_t c;
      int    n = 0;
      c = rand_cmd(1'b0);
      c.rd = 5'd7;
      npu_cmd_ready = 1'b1;
      wb_ready = 1'b0;
      drive_issue(c);
      tick();
      issue_valid = 1'b0;
      vecs++; if (npu_cmd_valid !== 1'b1) begin errs++; $display("FAIL tmo issue got 0 exp 1"); end
      while (n < TMO + 8) begin
         tick();
         n++;
         if (wb_valid) break;
      end
      npu_cmd_ready = 1'b0;
      vecs++; if (n != TMO) begin errs++; $display("FAIL tmo latency got %0d exp %0d", n, TMO); end
      vecs++;
      if (wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_data !== '1 || err !== 1'b1) begin
         errs++;
         $display("FAIL tmo wb got v=%b rd=%0d data=%h err=%b exp 1 7 ffff.. 1",
                  wb_valid, wb_rd, wb_data, err);
      end
      npu_done = 1'b1;
      npu_result = 64'h1234;
      tick();
      npu_done = 1'b0;
      vecs++;
      if (wb_valid !== 1'b1 || wb_data !== '1) begin
         errs++;
         $display("FAIL tmo late_done got v=%b data=%h exp 1 ffff..", wb_valid, wb_data);
      end
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      npu_done = 1'b1;
      tick();
      npu_done = 1'b0;
      tick();
      vecs++;
      if (wb_valid !== 1'b0 || busy !== 1'b0 || npu_cmd_valid !== 1'b0 || err !== 1'b1) begin
         errs++;
         $display("FAIL tmo idle got wb=%b busy=%b v=%b err=%b exp 0 0 0 1",
                  wb_valid, busy, npu_cmd_valid, err);
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      vecs++; if (err !== 1'b0) begin errs++; $display("FAIL tmo err_clr got %b exp 0", err); end
      idle_inputs();
   endtask

   task automatic test_flush();
      mcmd_t c0, c1, c2, c3;
      logic [63:0] r;
      bit leaked = 1'b0;
      c0 = rand_cmd(1'b0);
      c0.rd = 5'd9;
      c1 = rand_cmd(1'b0);
      c2 = rand_cmd(1'b0);
      c3 = rand_cmd(1'b0);
      r  = {$urandom, $urandom};
      npu_cmd_ready = 1'b1;
      wb_ready = 1'b1;
      drive_issue(c0);
      tick();
      issue_valid = 1'b0;
      tick();
      drive_issue(c1);
      tick();
      drive_issue(c2);
      tick();
      vecs++; if (issue_ready !== 1'b0) begin errs++; $display("FAIL flush full got %b exp 0", issue_ready); end
      drive_issue(c3);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      issue_valid = 1'b0;
      vecs++;
      if (issue_ready !== 1'b1 || busy !== 1'b1) begin
         errs++;
         $display("FAIL flush after got ready=%b busy=%b exp 1 1", issue_ready, busy);
      end
      npu_done = 1'b1;
      npu_result = r;
      tick();
      npu_done = 1'b0;
      vecs++;
      if (wb_valid !== 1'b1 || wb_rd !== 5'd9 || wb_data !== r) begin
         errs++;
         $display("FAIL flush wb got v=%b rd=%0d data=%h exp 1 9 %h", wb_valid, wb_rd, wb_data, r);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         if (npu_cmd_valid !== 1'b0 || wb_valid !== 1'b0) leaked = 1'b1;
      end
      vecs++; if (leaked) begin errs++; $display("FAIL flush leak got issue after flush exp none"); end
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL flush busy got %b exp 0", busy); end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      mcmd_t c0, c1, c2;
      c0 = rand_cmd(1'b0);
      c1 = rand_cmd(1'b0);
      c2 = rand_cmd(1'b0);
      npu_cmd_ready = 1'b1;
      drive_issue(c0);
      tick();
      drive_issue(c1);
      tick();
      issue_valid = 1'b0;
      tick();
      #2;
      rst = 1'b1;
      #1;
      vecs++;
      if (npu_cmd_valid !== 1'b0 || npu_cmd_op !== NPU_NONE || npu_cmd_a !== '0 ||
          npu_cmd_b !== '0 || wb_valid !== 1'b0 || wb_rd !== '0 || wb_data !== '0) begin
         errs++;
         $display("FAIL rstmid cmd/wb got v=%b op=%0d a=%h wb=%b rd=%0d exp all 0",
                  npu_cmd_valid, npu_cmd_op, npu_cmd_a, wb_valid, wb_rd);
      end
      vecs++;
      if (busy !== 1'b0 || err !== 1'b0 || issue_ready !== 1'b1) begin
         errs++;
         $display("FAIL rstmid status got busy=%b err=%b ready=%b exp 0 0 1", busy, err, issue_ready);
      end
      idle_inputs();
      tick();
      rst = 1'b0;
      model_clear();
      tick();
      rnd = 1'b0;
      drive_issue(c2);
      exp_cmd.push_back(c2);
      tick();
      issue_valid = 1'b0;
      vecs++; if (npu_cmd_valid !== 1'b1) begin errs++; $display("FAIL rstmid reissue got 0 exp 1"); end
      drain(100);
   endtask

   task automatic test_random();
      mcmd_t cur;
      int    npush = 0;
      rnd = 1'b1;
      issue_valid = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         bit acc;
         if (!issue_valid && npush < 60 && $urandom_range(0, 2) != 0) begin
            cur = rand_cmd(1'b1);
            drive_issue(cur);
         end
         acc = issue_valid && issue_ready;
         if (acc) exp_cmd.push_back(cur);
         agent_step();
         tick();
         if (acc) begin
            issue_valid = 1'b0;
            npush++;
         end
      end
      issue_valid = 1'b0;
      drain(2000);
      vecs++; if (npush != 60) begin errs++; $display("FAIL random pushes got %0d exp 60", npush); end
      rnd = 1'b0;
   endtask

   initial begin
      model_clear();
      rnd = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_rd0();
      test_timeout();
      test_flush();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
